// File: rtl/systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl
//
// Job sequencer for a DIMENSION x DIMENSION systolic matrix-multiply array.
// For each job it optionally clears the array edge, then generates the
// diagonally skewed operand feed (indices and enables), waits for the
// far-corner PE finish flag, and then steps the result-row select for
// readout. Readout stalls while the downstream FIFO is full.
//
// Compile-time option:
//   SYSTOLIC_CTRL_CLEAR_EN  defined   : CLEAR state present, o_clear is pulsed
//                           undefined : IDLE goes straight to FEED, o_clear = 0
//
// Parameters
//   DIMENSION    array side and operand vector length K
//   IDX_BITS     width of one feed index and of the row select
//   FIN_TIMEOUT  WAIT_FIN cycles allowed before flagging an error
//
// Ports
//   i_clock          rising-edge clock
//   i_reset          synchronous active-high reset
//   i_start          job request, only honoured in IDLE
//   rf_matrix_size   output-scaling select, latched at start
//   i_array_finish   o_finish of PE[D-1][D-1]
//   i_hold           downstream FIFO full, stalls READOUT only
//   o_valid          i_valid to every PE
//   o_clear          edge i_a_reset / i_b_reset
//   o_feed_en        per row/column: operand buffer presents real data
//   o_feed_idx       per row/column element index k (IDX_BITS each)
//   o_size           latched rf_matrix_size
//   o_rd_row         result row selected onto the readout bus
//   o_rd_valid       selected row's result is valid this cycle
//   o_busy           high in every state except IDLE
//   o_done           one-cycle job-complete pulse
//   o_error          one-cycle finish-timeout pulse
// ---------------------------------------------------------------------------
module systolic_seq_ctrl #(
  parameter int DIMENSION   = 4,
  parameter int IDX_BITS    = $clog2(DIMENSION),
  parameter int FIN_TIMEOUT = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic [2:0]                    rf_matrix_size,
  input  logic                          i_array_finish,
  input  logic                          i_hold,
  output logic                          o_valid,
  output logic                          o_clear,
  output logic [DIMENSION-1:0]          o_feed_en,
  output logic [DIMENSION*IDX_BITS-1:0] o_feed_idx,
  output logic [2:0]                    o_size,
  output logic [IDX_BITS-1:0]           o_rd_row,
  output logic                          o_rd_valid,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error
);

  // state      | meaning
  // -----------+-------------------------------------------------------------
  // S_IDLE     | waiting for i_start; o_error may pulse here after a timeout
  // S_CLEAR    | 2D-1 cycles: o_clear on the first, lets the reset chain
  //            | propagate to PE[D-1][D-1]
  // S_FEED     | 3D-2 cycles of skewed operand feed, t = 0..3D-3
  // S_WAIT_FIN | waiting for the far-corner finish flag, bounded by timeout
  // S_READOUT  | row select 0..D-1, advancing only when i_hold is low
  // S_DONE     | one-cycle o_done, then IDLE

  // The single counter t must span the longest state (FEED or WAIT_FIN).
  localparam int T_MAX = (3 * DIMENSION > FIN_TIMEOUT) ? 3 * DIMENSION : FIN_TIMEOUT;
  localparam int T_W   = $clog2(T_MAX + 1);

  localparam logic [T_W-1:0] T_ONE      = T_W'(1);
  localparam logic [T_W-1:0] CLEAR_LAST = T_W'(2 * DIMENSION - 2);
  localparam logic [T_W-1:0] FEED_LAST  = T_W'(3 * DIMENSION - 3);
  localparam logic [T_W-1:0] FIN_LAST   = T_W'(FIN_TIMEOUT - 1);
  localparam logic [T_W-1:0] ROW_LAST   = T_W'(DIMENSION - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_FEED     = 3'd2,
    S_WAIT_FIN = 3'd3,
    S_READOUT  = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  state_e                        state_q,     state_d;
  logic [T_W-1:0]                t_q,         t_d;
  logic [2:0]                    size_q,      size_d;
  logic                          error_q,     error_d;
  logic                          busy_q,      busy_d;
  logic                          valid_q,     valid_d;
  logic                          clear_q,     clear_d;
  logic [DIMENSION-1:0]          feed_en_q,   feed_en_d;
  logic [DIMENSION*IDX_BITS-1:0] feed_idx_q,  feed_idx_d;
  logic [IDX_BITS-1:0]           rd_row_q,    rd_row_d;
  logic                          rd_active_q, rd_active_d;
  logic                          done_q,      done_d;

  // -------------------------------------------------------------------------
  // Next-state and counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    size_d  = size_q;
    error_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          size_d = rf_matrix_size;
          t_d    = '0;
`ifdef SYSTOLIC_CTRL_CLEAR_EN
          state_d = S_CLEAR;
`else
          state_d = S_FEED;
`endif
        end
      end

      S_CLEAR: begin
        if (t_q == CLEAR_LAST) begin
          state_d = S_FEED;
          t_d     = '0;
        end else begin
          t_d = t_q + T_ONE;
        end
      end

      S_FEED: begin
        if (t_q == FEED_LAST) begin
          state_d = S_WAIT_FIN;
          t_d     = '0;
        end else begin
          t_d = t_q + T_ONE;
        end
      end

      S_WAIT_FIN: begin
        // Finish takes priority, so a flag arriving in the last allowed
        // cycle still completes the job.
        if (i_array_finish) begin
          state_d = S_READOUT;
          t_d     = '0;
        end else if (t_q == FIN_LAST) begin
          state_d = S_IDLE;
          t_d     = '0;
          error_d = 1'b1;
        end else begin
          t_d = t_q + T_ONE;
        end
      end

      S_READOUT: begin
        if (!i_hold) begin
          if (t_q == ROW_LAST) begin
            state_d = S_DONE;
            t_d     = '0;
          end else begin
            t_d = t_q + T_ONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        t_d     = '0;
      end

      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state so every output is a flop
  // -------------------------------------------------------------------------
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    valid_d     = (state_d == S_CLEAR) || (state_d == S_FEED);
    rd_active_d = (state_d == S_READOUT);
    done_d      = (state_d == S_DONE);
    rd_row_d    = rd_active_d ? t_d[IDX_BITS-1:0] : '0;

`ifdef SYSTOLIC_CTRL_CLEAR_EN
    clear_d = (state_d == S_CLEAR) && (t_d == '0);
`else
    clear_d = 1'b0;
`endif

    // Row/column i carries element k = t-i during its D-cycle window,
    // which produces the diagonal skew across the array edge.
    feed_en_d  = '0;
    feed_idx_d = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < DIMENSION; i++) begin
        if ((t_d >= T_W'(i)) && (t_d <= T_W'(i + DIMENSION - 1))) begin
          feed_en_d[i]                        = 1'b1;
          feed_idx_d[i*IDX_BITS +: IDX_BITS] = IDX_BITS'(t_d - T_W'(i));
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      size_q      <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      clear_q     <= 1'b0;
      feed_en_q   <= '0;
      feed_idx_q  <= '0;
      rd_row_q    <= '0;
      rd_active_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      size_q      <= size_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      clear_q     <= clear_d;
      feed_en_q   <= feed_en_d;
      feed_idx_q  <= feed_idx_d;
      rd_row_q    <= rd_row_d;
      rd_active_q <= rd_active_d;
      done_q      <= done_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_clear    = clear_q;
  assign o_feed_en  = feed_en_q;
  assign o_feed_idx = feed_idx_q;
  assign o_size     = size_q;
  assign o_rd_row   = rd_row_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

  // The FIFO-full flag must suppress the push in the same cycle it is
  // raised, so rd_valid is the registered readout phase gated by i_hold.
  assign o_rd_valid = rd_active_q & ~i_hold;

endmodule
